// File: rtl/alu_sequencer.sv
// alu_sequencer
// ---------------------------------------------------------------------------
// Command-driven controller for the 10-bit accumulator ALU. It accepts one
// command at a time over a valid/ready handshake. It drives the ALU opcode and
// operand inputs, and captures each ALU result into a local accumulator. An
// operation repeats up to 15 times. The final value is reported with a
// one-cycle done pulse.
//
// Optional feature macro: ALU_SEQ_ZERO_STOP_EN
//   When defined, SUB and SHIFT commands stop early once the captured value
//   is zero. When undefined, all cmd_count iterations always execute.
//
// Ports
//   clk          in   1   clock; state updates on posedge (ALU uses negedge)
//   rst          in   1   synchronous active-high reset
//   cmd_valid    in   1   command present
//   cmd_ready    out  1   command can be accepted (IDLE only)
//   cmd_opcode   in   3   001 ADD, 010 SUB, 011 INC, 100 SHIFT, others illegal
//   cmd_operand  in   8   ADD/SUB operand, or the load value
//   cmd_count    in   4   iteration count 0..15
//   cmd_load     in   1   load accumulator with {2'b00, cmd_operand}
//   alu_opcode   out  3   ALU opcode, 000 (hold) outside ISSUE/CAPTURE
//   alu_in1      out  8   latched command operand
//   alu_in2      out  10  current accumulator
//   alu_out      in   10  ALU result
//   busy         out  1   high in every state except IDLE
//   done         out  1   one-cycle completion pulse
//   result       out  10  accumulator value, stable until the next done
//   zero         out  1   result == 0, registered with done
//   err          out  1   illegal opcode, registered with done
// ---------------------------------------------------------------------------
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_opcode,
  input  logic [7:0] cmd_operand,
  input  logic [3:0] cmd_count,
  input  logic       cmd_load,
  output logic [2:0] alu_opcode,
  output logic [7:0] alu_in1,
  output logic [9:0] alu_in2,
  input  logic [9:0] alu_out,
  output logic       busy,
  output logic       done,
  output logic [9:0] result,
  output logic       zero,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_INC   = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;

  state_t     r_state;
  logic [9:0] r_acc;
  logic [7:0] r_operand;
  logic [3:0] r_remaining;
  logic [2:0] r_aluOpcode;
  logic       r_ready;
  logic       r_busy;
  logic       r_done;
  logic [9:0] r_result;
  logic       r_zero;
  logic       r_err;

  logic       w_legalOp;
  logic       w_zeroStop;

  // An opcode is legal only if it is one of the four ALU operations.
  assign w_legalOp = (cmd_opcode == OP_ADD) || (cmd_opcode == OP_SUB) ||
                     (cmd_opcode == OP_INC) || (cmd_opcode == OP_SHIFT);

  // Early termination for SUB/SHIFT. r_aluOpcode still holds the running
  // opcode during CAPTURE, so no separate copy of the command opcode is needed.
`ifdef ALU_SEQ_ZERO_STOP_EN
  assign w_zeroStop = ((r_aluOpcode == OP_SUB) || (r_aluOpcode == OP_SHIFT)) &&
                      (alu_out == 10'd0);
`else
  assign w_zeroStop = 1'b0;
`endif

  // Sequencer FSM with every output registered. The completion outputs
  // (done/result/zero/err) are loaded on the edge that enters DONE. Each
  // branch therefore uses the value the accumulator is about to take, not
  // its current contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= 10'd0;
      r_operand   <= 8'd0;
      r_remaining <= 4'd0;
      r_aluOpcode <= OP_HOLD;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= 10'd0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_ready) begin
            r_operand   <= cmd_operand;
            r_remaining <= cmd_count;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_load) begin
              r_acc    <= {2'b00, cmd_operand};
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_result <= {2'b00, cmd_operand};
              r_zero   <= (cmd_operand == 8'd0);
              r_err    <= 1'b0;
            end else if (!w_legalOp || (cmd_count == 4'd0)) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_result <= r_acc;
              r_zero   <= (r_acc == 10'd0);
              r_err    <= !w_legalOp;
            end else begin
              r_state     <= ISSUE;
              r_aluOpcode <= cmd_opcode;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        ISSUE: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_acc       <= alu_out;
          r_remaining <= r_remaining - 4'd1;
          if ((r_remaining == 4'd1) || w_zeroStop) begin
            r_state     <= DONE;
            r_aluOpcode <= OP_HOLD;
            r_done      <= 1'b1;
            r_result    <= alu_out;
            r_zero      <= (alu_out == 10'd0);
            r_err       <= 1'b0;
          end else begin
            r_state <= ISSUE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_ready;
  assign alu_opcode = r_aluOpcode;
  assign alu_in1    = r_operand;
  assign alu_in2    = r_acc;
  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign zero       = r_zero;
  assign err        = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// ---------------------------------------------------------------------------
// Self-checking bench for alu_sequencer. It contains a negedge ALU model that
// drives alu_out, and an accumulator reference model built from the command
// rules. Reference results are computed with plain integer arithmetic.
// Honours ALU_SEQ_ZERO_STOP_EN so the expected latencies follow the build.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_opcode;
  logic [7:0] cmd_operand;
  logic [3:0] cmd_count;
  logic       cmd_load;
  logic [2:0] alu_opcode;
  logic [7:0] alu_in1;
  logic [9:0] alu_in2;
  logic [9:0] alu_out = 10'd0;
  logic       busy;
  logic       done;
  logic [9:0] result;
  logic       zero;
  logic       err;

  int checks = 0;
  int errors = 0;
  int modelAcc = 0;

  typedef struct {
    bit         load;
    logic [2:0] op;
    logic [7:0] operand;
    logic [3:0] count;
    logic [9:0] expRes;
    bit         expErr;
    int         expLat;
  } planEntry_t;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_operand (cmd_operand),
    .cmd_count   (cmd_count),
    .cmd_load    (cmd_load),
    .alu_opcode  (alu_opcode),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .err         (err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Environment model of the ALU: it samples its inputs on the falling edge
  // and holds its output for opcode 000 and any unused code.
  always @(negedge clk) begin
    case (alu_opcode)
      3'b001:  alu_out <= alu_in2 + {2'b00, alu_in1};
      3'b010:  alu_out <= alu_in2 - {2'b00, alu_in1};
      3'b011:  alu_out <= alu_in2 + 10'd1;
      3'b100:  alu_out <= alu_in2 >> 2;
      default: alu_out <= alu_out;
    endcase
  end

  // Watchdog so the run always ends even if the DUT locks up.
  initial begin
    #700000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: applies one command to modelAcc. It returns the expected
  // result, err flag, and cycle distance from handshake to done.
  task automatic modelCommand(input bit load, input logic [2:0] op,
                              input logic [7:0] operand, input logic [3:0] count,
                              output logic [9:0] expRes, output bit expErr,
                              output int expLat);
    int k;
    expErr = 1'b0;
    expLat = 1;
    if (load) begin
      modelAcc = int'(operand);
    end else if (op < 3'd1 || op > 3'd4) begin
      expErr = 1'b1;
    end else if (count != 4'd0) begin
      k = 0;
      for (int i = 0; i < int'(count); i++) begin
        case (op)
          3'd1: modelAcc = (modelAcc + int'(operand)) % 1024;
          3'd2: modelAcc = (modelAcc - int'(operand) + 1024) % 1024;
          3'd3: modelAcc = (modelAcc + 1) % 1024;
          default: modelAcc = modelAcc / 4;
        endcase
        k++;
`ifdef ALU_SEQ_ZERO_STOP_EN
        if ((op == 3'd2 || op == 3'd4) && modelAcc == 0) break;
`endif
      end
      expLat = 2 * k + 1;
    end
    expRes = 10'(modelAcc);
  endtask

  // Issues one command and waits for its done pulse. It reports the observed
  // latency, completion outputs, whether done stayed high a second cycle,
  // and whether an ALU opcode was ever driven.
  task automatic applyStimulus(input bit load, input logic [2:0] op,
                               input logic [7:0] operand, input logic [3:0] count,
                               output int lat, output logic [9:0] res,
                               output logic z, output logic e,
                               output logic doneAfter, output logic aluActive);
    int waitCycles;
    aluActive  = 1'b0;
    waitCycles = 0;
    while (cmd_ready !== 1'b1 && waitCycles < 50) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL ready_timeout got cmd_ready=%b want 1", cmd_ready);
    end
    cmd_valid   = 1'b1;
    cmd_load    = load;
    cmd_opcode  = op;
    cmd_operand = operand;
    cmd_count   = count;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (alu_opcode !== 3'b000) aluActive = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL done_timeout got done=%b want 1 within 100 cycles", done);
    end
    res = result;
    z   = zero;
    e   = err;
    @(posedge clk); #1;
    doneAfter = done;
  endtask

  // Reset values and ready rising once reset is released.
  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_load = 1'b0; cmd_opcode = 3'd0;
    cmd_operand = 8'd0; cmd_count = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (zero !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got zero=%b err=%b want 0 0", zero, err); end
    checks++; if (result !== 10'd0) begin errors++; $display("[TB] FAIL reset_result got %h want 000", result); end
    checks++; if (alu_opcode !== 3'd0 || alu_in1 !== 8'd0 || alu_in2 !== 10'd0) begin
      errors++; $display("[TB] FAIL reset_alu got op=%h in1=%h in2=%h want 0 0 0", alu_opcode, alu_in1, alu_in2);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %b want 1", cmd_ready); end
    modelAcc = 0;
  endtask

  // Directed scenario with hand-derived constants for results and latencies.
  task automatic test_plan();
    planEntry_t plan[$];
    int shiftLat;
    int lat;
    int mLat;
    logic [9:0] res;
    logic [9:0] mRes;
    logic z, e, da, act;
    bit mErr;
`ifdef ALU_SEQ_ZERO_STOP_EN
    shiftLat = 11;
`else
    shiftLat = 17;
`endif
    plan.push_back('{1'b1, 3'd0, 8'd5,    4'd0,  10'h005, 1'b0, 1});
    plan.push_back('{1'b0, 3'd1, 8'd3,    4'd4,  10'h011, 1'b0, 9});
    plan.push_back('{1'b0, 3'd2, 8'd20,   4'd1,  10'h3FD, 1'b0, 3});
    plan.push_back('{1'b0, 3'd4, 8'd0,    4'd8,  10'h000, 1'b0, shiftLat});
    plan.push_back('{1'b1, 3'd7, 8'h80,   4'd5,  10'h080, 1'b0, 1});
    plan.push_back('{1'b0, 3'd6, 8'h11,   4'd3,  10'h080, 1'b1, 1});
    plan.push_back('{1'b0, 3'd0, 8'h22,   4'd0,  10'h080, 1'b1, 1});
    plan.push_back('{1'b0, 3'd1, 8'h33,   4'd0,  10'h080, 1'b0, 1});
    plan.push_back('{1'b1, 3'd0, 8'hFF,   4'd0,  10'h0FF, 1'b0, 1});
    plan.push_back('{1'b0, 3'd3, 8'd0,    4'd15, 10'h10E, 1'b0, 31});
    foreach (plan[i]) begin
      applyStimulus(plan[i].load, plan[i].op, plan[i].operand, plan[i].count, lat, res, z, e, da, act);
      modelCommand(plan[i].load, plan[i].op, plan[i].operand, plan[i].count, mRes, mErr, mLat);
      checks++; if (res !== plan[i].expRes) begin errors++; $display("[TB] FAIL plan%0d_result got %h want %h", i, res, plan[i].expRes); end
      checks++; if (z !== (plan[i].expRes == 10'd0)) begin errors++; $display("[TB] FAIL plan%0d_zero got %b want %b", i, z, plan[i].expRes == 10'd0); end
      checks++; if (e !== plan[i].expErr) begin errors++; $display("[TB] FAIL plan%0d_err got %b want %b", i, e, plan[i].expErr); end
      checks++; if (lat != plan[i].expLat) begin errors++; $display("[TB] FAIL plan%0d_latency got %0d want %0d", i, lat, plan[i].expLat); end
      checks++; if (da !== 1'b0) begin errors++; $display("[TB] FAIL plan%0d_pulse got done=%b want 0 after one cycle", i, da); end
      checks++; if (act !== (plan[i].expLat > 1)) begin errors++; $display("[TB] FAIL plan%0d_alu_issue got %b want %b", i, act, plan[i].expLat > 1); end
    end
  endtask

  // Step INC one at a time from 0x0FF up to 0x3FF, then wrap to zero.
  task automatic test_inc_wrap();
    int lat, mLat;
    logic [9:0] res, mRes;
    logic z, e, da, act;
    bit mErr;
    applyStimulus(1'b1, 3'd0, 8'hFF, 4'd0, lat, res, z, e, da, act);
    modelCommand(1'b1, 3'd0, 8'hFF, 4'd0, mRes, mErr, mLat);
    for (int v = 'h100; v <= 'h400; v++) begin
      applyStimulus(1'b0, 3'd3, 8'd0, 4'd1, lat, res, z, e, da, act);
      modelCommand(1'b0, 3'd3, 8'd0, 4'd1, mRes, mErr, mLat);
      checks++; if (res !== 10'(v % 1024)) begin errors++; $display("[TB] FAIL inc_step got %h want %h", res, 10'(v % 1024)); end
      checks++; if (lat != 3) begin errors++; $display("[TB] FAIL inc_latency got %0d want 3", lat); end
    end
    checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL inc_wrap_zero got %b want 1", z); end
  endtask

  // Reset during CAPTURE of a long ADD, with cmd_valid held through reset.
  task automatic test_reset_mid();
    int lat, mLat, doneSeen;
    logic [9:0] res, mRes;
    logic z, e, da, act;
    bit mErr;
    applyStimulus(1'b1, 3'd0, 8'h33, 4'd0, lat, res, z, e, da, act);
    modelCommand(1'b1, 3'd0, 8'h33, 4'd0, mRes, mErr, mLat);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_opcode = 3'd1;
    cmd_operand = 8'd1; cmd_count = 4'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    doneSeen = 0;
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 8'h55;
    repeat (2) begin
      @(posedge clk); #1;
      if (done === 1'b1) doneSeen++;
    end
    checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL midreset_done got %0d pulses want 0", doneSeen); end
    checks++; if (result !== 10'd0) begin errors++; $display("[TB] FAIL midreset_result got %h want 000", result); end
    checks++; if (alu_opcode !== 3'd0) begin errors++; $display("[TB] FAIL midreset_opcode got %h want 0", alu_opcode); end
    checks++; if (alu_in2 !== 10'd0) begin errors++; $display("[TB] FAIL midreset_acc got %h want 000", alu_in2); end
    rst = 1'b0;
    modelAcc = 0;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready got %b want 1", cmd_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_late_done got %b want 0", done); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    modelCommand(1'b1, 3'd0, 8'h55, 4'd0, mRes, mErr, mLat);
    checks++; if (done !== 1'b1 || result !== 10'h055) begin
      errors++; $display("[TB] FAIL midreset_load got done=%b result=%h want 1 055", done, result);
    end
    @(posedge clk); #1;
  endtask

  // cmd_valid held high during busy: the second command waits for IDLE.
  task automatic test_back_to_back();
    int lat, mLat, readyWhileBusy;
    logic [9:0] mRes;
    bit mErr;
    while (cmd_ready !== 1'b1) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_opcode = 3'd1;
    cmd_operand = 8'd7; cmd_count = 4'd3;
    @(posedge clk); #1;
    modelCommand(1'b0, 3'd1, 8'd7, 4'd3, mRes, mErr, mLat);
    cmd_load = 1'b1; cmd_operand = 8'h2A;
    lat = 1;
    readyWhileBusy = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (cmd_ready !== 1'b0) readyWhileBusy++;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (readyWhileBusy != 0) begin errors++; $display("[TB] FAIL b2b_ready_busy got %0d cycles want 0", readyWhileBusy); end
    checks++; if (lat != mLat) begin errors++; $display("[TB] FAIL b2b_latency got %0d want %0d", lat, mLat); end
    checks++; if (result !== mRes) begin errors++; $display("[TB] FAIL b2b_first_result got %h want %h", result, mRes); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_in_done got %b want 0", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_idle got ready=%b done=%b want 1 0", cmd_ready, done);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    modelCommand(1'b1, 3'd0, 8'h2A, 4'd0, mRes, mErr, mLat);
    checks++; if (done !== 1'b1 || result !== mRes) begin
      errors++; $display("[TB] FAIL b2b_second got done=%b result=%h want 1 %h", done, result, mRes);
    end
    @(posedge clk); #1;
  endtask

  // Random commands, including loads, illegal codes and zero counts.
  task automatic test_random();
    int lat, mLat;
    logic [9:0] res, mRes;
    logic z, e, da, act;
    bit mErr;
    bit load;
    logic [2:0] op;
    logic [7:0] operand;
    logic [3:0] count;
    for (int n = 0; n < 60; n++) begin
      load    = ($urandom_range(0, 3) == 0);
      op      = 3'($urandom_range(0, 7));
      operand = 8'($urandom);
      count   = 4'($urandom_range(0, 15));
      applyStimulus(load, op, operand, count, lat, res, z, e, da, act);
      modelCommand(load, op, operand, count, mRes, mErr, mLat);
      checks++; if (res !== mRes) begin errors++; $display("[TB] FAIL rand%0d_result got %h want %h", n, res, mRes); end
      checks++; if (z !== (mRes == 10'd0)) begin errors++; $display("[TB] FAIL rand%0d_zero got %b want %b", n, z, mRes == 10'd0); end
      checks++; if (e !== mErr) begin errors++; $display("[TB] FAIL rand%0d_err got %b want %b", n, e, mErr); end
      checks++; if (lat != mLat) begin errors++; $display("[TB] FAIL rand%0d_latency got %0d want %0d", n, lat, mLat); end
      checks++; if (da !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_pulse got done=%b want 0", n, da); end
      checks++; if (act !== (mLat > 1)) begin errors++; $display("[TB] FAIL rand%0d_alu_issue got %b want %b", n, act, mLat > 1); end
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_inc_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
